write_stack_burst: RTL
======================

Name: write_stack_burst

Overview:
- Sequential successor to the combinational push-address/limit checker.
- Performs a burst of 1..MAX_PUSHES stack pushes, e.g. interrupt, far-call or task-switch frames, on either the current SS or a newly loaded stack descriptor.
- Per push: computes the decremented offset and the linear address, checks the segment rules, then issues one write request with a req/done handshake.
- Sits between the write stage microcode and the memory write port.

Parameters:
- MAX_PUSHES, 8, maximum pushes per burst.
- CNT_W, 4, width of the count fields; must satisfy 2^CNT_W > MAX_PUSHES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle burst request; ignored unless idle
- count  in  CNT_W  number of pushes; values above MAX_PUSHES are clamped to MAX_PUSHES
- length_dword  in  1  1 = 4-byte pushes, 0 = 2-byte pushes
- esp_in  in  32  starting ESP
- d_b  in  1  stack descriptor D/B bit
- seg_base  in  32  stack segment base
- seg_limit  in  32  stack segment limit (already granularity-scaled)
- seg_type  in  4  descriptor bits 43:40 (code, expand-down, writable, accessed)
- new_stack  in  1  1 = apply the code/read-only fault rule as well
- fault_check  in  1  enable limit checks
- push_index  out  CNT_W  index of the current push; the source drives push_data combinationally from it
- push_data  in  32  data for the current push
- wr_req  out  1  write request
- wr_linear  out  32  linear address
- wr_data  out  32  write data
- wr_length  out  3  2 or 4
- wr_done  in  1  write accepted
- busy  out  1  high from the cycle after start until done/fault
- done  out  1  one-cycle pulse on success
- fault  out  1  one-cycle pulse on an SS fault
- esp_out  out  32  resulting ESP, valid with done
- wr_count  out  CNT_W  number of completed writes

Behaviour:
- Reset: all outputs are 0. State goes to IDLE, and an in-flight wr_req is dropped immediately.
- States and transitions:
  - IDLE: on start, latch all inputs, set push_index=0, then go to CHECK.
  - CHECK: compute offset = cur − len. If d_b=0, compute it in 16-bit, wrapping 0x0000 − 2 to 0xFFFE. Then evaluate the fault rules below.
  - CHECK outcome: on fault go to FAULT; otherwise go to REQ.
  - REQ: drive wr_req=1, wr_linear = seg_base + offset (mod 2^32), wr_data = push_data, wr_length = len. Hold these stable until wr_done.
  - REQ on wr_done in the same cycle: set cur = offset, increment wr_count, then go to CHECK if more pushes remain, else to DONE. wr_req is low in the following cycle.
  - DONE: pulse done; esp_out = offset if d_b=1, else {esp_in[31:16], offset[15:0]}. Return to IDLE.
  - FAULT: pulse fault; esp_out = esp_in, so ESP is never partially updated. Return to IDLE.
- count=0: go directly to DONE. done pulses 2 cycles after start, with zero writes and esp_out = esp_in.
- Fault rules (only when fault_check=1):
  - upper = 0xFFFFFFFF if d_b=1, else 0x0000FFFF.
  - Normal segment (code or not expand-down): fault if offset > limit, or if limit − offset < len − 1.
  - Expand-down data segment: fault if offset ≤ limit, or offset > upper, or upper − offset < len − 1.
  - When new_stack=1, additionally fault if seg_type[3]=1 (code) or seg_type[1]=0 (read-only).
- Latency: start to first wr_req is 2 cycles; each further push costs 1 CHECK cycle plus the handshake.
- start during busy is ignored. wr_done outside REQ is ignored.

Optional Feature:
- Macro: WRITE_STACK_BURST_PRECHECK_EN.
- Defined: CHECK for push 0 also checks the whole frame. Lowest offset = esp_in − count·len, checked against the same rules, and a wrap below 0 (or below 0 in 16-bit when d_b=0) faults. Fault guarantees wr_count=0.
- Undefined: checks are per push only. A fault may occur after some writes; wr_count reports how many completed.

Test Plan:
- d_b=1, esp_in=0x1000, base=0x20000, limit=0xFFFFF, count=3, dword, wr_done 1 cycle after each req → linears 0x20FFC, 0x20FF8, 0x20FF4; esp_out=0x0FF4; done pulses; wr_count=3.
- d_b=0, esp_in=0xABCD0002, count=2, word, limit=0xFFFF → offsets 0x0000 then 0xFFFE (wrap); esp_out=0xABCDFFFE; no fault.
- Normal segment, limit=0x0FFF, esp_in=0x1002, count=1, dword → offset 0x0FFE, limit − offset = 1 < 3 → fault pulse, zero writes, esp_out=0x1002.
- Expand-down, d_b=0, limit=0x0FFF, esp_in=0x1008, count=3, dword → pushes 0 and 1 write; push 2 (offset 0x0FFC) faults → wr_count=2 without the macro; with the macro, fault before any write.
- new_stack=1, seg_type=4'b0000 (read-only data) → fault in first CHECK; wr_req never asserted.
- rst asserted while wr_req=1 → wr_req, busy, fault and done are all 0 asynchronously; a subsequent start with count=0 → done 2 cycles later.

Source files
------------

// File: rtl/write_stack_burst.sv
// rtl/write_stack_burst.sv - burst stack-push sequencer with segment limit checks
//
// Purpose: performs 1..MAX_PUSHES pushes (2 or 4 bytes each) on the stack
// described by seg_base/seg_limit/seg_type. For each push it decrements the
// offset, checks the segment rules and issues one write over a req/done
// handshake. On success it reports the final ESP; on a fault it reports the
// original ESP unchanged.
//
// Optional feature macro: WRITE_STACK_BURST_PRECHECK_EN
//   defined   - the first CHECK also validates the lowest offset of the whole
//               frame (and 16/32-bit wrap), so a fault never follows a write.
//   undefined - per-push checks only; wr_count tells how many writes landed.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle burst request (ignored unless idle)
//   count             pushes in the burst, clamped to MAX_PUSHES
//   length_dword      1 = 4-byte pushes, 0 = 2-byte pushes
//   esp_in, d_b       starting ESP and stack D/B bit
//   seg_base/limit    stack segment base and scaled limit
//   seg_type          descriptor type bits (code, expand-down, writable, accessed)
//   new_stack         also apply the code/read-only rule
//   fault_check       enable all fault rules
//   push_index        index of the current push; push_data follows it
//   push_data         data for the current push
//   wr_req/wr_linear/wr_data/wr_length, wr_done   memory write handshake
//   busy, done, fault burst status; done/fault are one-cycle pulses
//   esp_out           resulting ESP, valid with done/fault
//   wr_count          number of completed writes

module write_stack_burst #(
  parameter int MAX_PUSHES = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             length_dword,
  input  logic [31:0]      esp_in,
  input  logic             d_b,
  input  logic [31:0]      seg_base,
  input  logic [31:0]      seg_limit,
  input  logic [3:0]       seg_type,
  input  logic             new_stack,
  input  logic             fault_check,
  output logic [CNT_W-1:0] push_index,
  input  logic [31:0]      push_data,
  output logic             wr_req,
  output logic [31:0]      wr_linear,
  output logic [31:0]      wr_data,
  output logic [2:0]       wr_length,
  input  logic             wr_done,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [31:0]      esp_out,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PUSHES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             dword_q;
  logic             d_b_q;
  logic             new_stack_q;
  logic             fchk_q;
  logic [31:0]      esp_in_q;
  logic [31:0]      base_q;
  logic [31:0]      limit_q;
  logic [3:1]       type_q;
  logic [31:0]      cur_q;
  logic [31:0]      off_q;

  // The accessed bit plays no part in the stack rules.
  logic unused_accessed;
  assign unused_accessed = seg_type[0];

  logic [31:0] len32;
  logic [1:0]  lenm1;
  logic [15:0] off16;
  logic [31:0] off_calc;
  logic [31:0] upper;
  logic        expand_down;
  logic        last_push;
  logic        chk_fault;

  // Segment rule for one offset; the caller guarantees off is already
  // reduced to 16 bits when the stack is 16-bit.
  function automatic logic rule_fault(input logic [31:0] off,
                                      input logic [31:0] limit,
                                      input logic [31:0] upr,
                                      input logic [1:0]  lm1,
                                      input logic        exp_down);
    logic [31:0] lm;
    lm = {30'd0, lm1};
    if (exp_down)
      return (off <= limit) || (off > upr) || ((upr - off) < lm);
    else
      return (off > limit) || ((limit - off) < lm);
  endfunction

  assign len32       = dword_q ? 32'd4 : 32'd2;
  assign lenm1       = dword_q ? 2'd3 : 2'd1;
  assign off16       = cur_q[15:0] - len32[15:0];
  assign off_calc    = d_b_q ? (cur_q - len32) : {16'h0000, off16};
  assign upper       = d_b_q ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  assign expand_down = !type_q[3] && type_q[2];
  assign last_push   = ((push_index + ONE) == cnt_q);

`ifdef WRITE_STACK_BURST_PRECHECK_EN
  logic [CNT_W+1:0] frame_bytes;
  logic [31:0]      frame32;
  logic             frame_wrap;
  logic [31:0]      frame_low;
  logic             frame_fault;

  assign frame_bytes = dword_q ? {cnt_q, 2'b00} : {1'b0, cnt_q, 1'b0};
  assign frame32     = {{(32-CNT_W-2){1'b0}}, frame_bytes};
  assign frame_wrap  = d_b_q ? (esp_in_q < frame32)
                             : ({16'h0000, esp_in_q[15:0]} < frame32);
  assign frame_low   = d_b_q ? (esp_in_q - frame32)
                             : {16'h0000, esp_in_q[15:0] - frame32[15:0]};
  // Only the first CHECK validates the whole frame.
  assign frame_fault = (push_index == '0) &&
                       (frame_wrap ||
                        rule_fault(frame_low, limit_q, upper, lenm1, expand_down));
`else
  logic frame_fault;
  assign frame_fault = 1'b0;
`endif

  assign chk_fault = fchk_q &&
                     (rule_fault(off_calc, limit_q, upper, lenm1, expand_down) ||
                      (new_stack_q && (type_q[3] || !type_q[1])) ||
                      frame_fault);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    wr_linear = 32'd0;
    wr_data   = 32'd0;
    wr_length = 3'd0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    fault     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // push_index only equals cnt_q here when the burst was empty.
        if (push_index == cnt_q) state_nxt = S_DONE;
        else if (chk_fault)      state_nxt = S_FAULT;
        else                     state_nxt = S_REQ;
      end
      S_REQ: begin
        wr_req    = 1'b1;
        wr_linear = base_q + off_q;
        wr_data   = push_data;
        wr_length = dword_q ? 3'd4 : 3'd2;
        if (wr_done) state_nxt = last_push ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAULT: begin
        fault     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      dword_q     <= 1'b0;
      d_b_q       <= 1'b0;
      new_stack_q <= 1'b0;
      fchk_q      <= 1'b0;
      esp_in_q    <= 32'd0;
      base_q      <= 32'd0;
      limit_q     <= 32'd0;
      type_q      <= 3'd0;
      cur_q       <= 32'd0;
      off_q       <= 32'd0;
      push_index  <= '0;
      wr_count    <= '0;
      esp_out     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt_q       <= (count > MAX_CNT) ? MAX_CNT : count;
            dword_q     <= length_dword;
            d_b_q       <= d_b;
            new_stack_q <= new_stack;
            fchk_q      <= fault_check;
            esp_in_q    <= esp_in;
            base_q      <= seg_base;
            limit_q     <= seg_limit;
            type_q      <= seg_type[3:1];
            cur_q       <= esp_in;
            push_index  <= '0;
            wr_count    <= '0;
          end
        end
        S_CHECK: begin
          off_q <= off_calc;
          if (push_index == cnt_q)
            esp_out <= d_b_q ? cur_q : {esp_in_q[31:16], cur_q[15:0]};
          else if (chk_fault)
            esp_out <= esp_in_q;
        end
        S_REQ: begin
          if (wr_done) begin
            cur_q      <= off_q;
            push_index <= push_index + ONE;
            wr_count   <= wr_count + ONE;
            if (last_push)
              esp_out <= d_b_q ? off_q : {esp_in_q[31:16], off_q[15:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
